// File: rtl/game_flow_ctrl.sv
// Maze game sequencer: greeting, level setup, logic/render loop, life loss, game over and win.
// Drives the shared VGA write port from the greeting, renderer, game-over or you-won source.
module game_flow_ctrl #(
  parameter int          NUM_GHOSTS   = 3,
  parameter int          LIVES        = 3,
  parameter int          MAX_LEVEL    = 4,
  parameter logic [7:0]  WIN_SCORE    = 8'd200,
  parameter logic [15:0] PAUSE_CYCLES = 16'd50000
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  start_n,
  input  logic [NUM_GHOSTS-1:0] ghost_hit,
  input  logic [7:0]            score,
  input  logic                  logic_done,
  input  logic                  render_done,
  input  logic                  screen_done,
  input  logic [31:0]           src_x,
  input  logic [27:0]           src_y,
  input  logic [47:0]           src_color,
  output logic                  e_greeting,
  output logic                  e_logic,
  output logic                  e_render,
  output logic                  e_game_over,
  output logic                  e_you_won,
  output logic                  new_game,
  output logic                  round_reset,
  output logic [2:0]            lives,
  output logic [3:0]            level,
  output logic [2:0]            state,
  output logic [7:0]            VGA_X,
  output logic [6:0]            VGA_Y,
  output logic [11:0]           VGA_COLOR,
  output logic                  VGA_PLOT
);

  typedef enum logic [2:0] {
    S_GREETING   = 3'd0,
    S_LEVEL_INIT = 3'd1,
    S_LOGIC      = 3'd2,
    S_RENDER     = 3'd3,
    S_LIFE_LOST  = 3'd4,
    S_GAME_OVER  = 3'd5,
    S_YOU_WON    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic        new_game_d;
  logic        new_game_q, round_reset_q;
  logic        e_greeting_q, e_logic_q, e_render_q, e_game_over_q, e_you_won_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic        press;
  logic        hit;
  logic        won_level;

  // Press is the falling edge seen at the second synchroniser stage.
  assign press     = sync3_q & ~sync2_q;
  assign hit       = |ghost_hit;
  assign won_level = (score >= WIN_SCORE);

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    new_game_d = 1'b0;
    case (state_q)
      S_GREETING: begin
        if (press) begin
          lives_d    = 3'(LIVES);
          level_d    = 4'd1;
          new_game_d = 1'b1;
          state_d    = S_LEVEL_INIT;
        end
      end
      S_LEVEL_INIT: state_d = S_LOGIC;
      S_LOGIC: begin
        if (logic_done) begin
          if (hit && lives_q == 3'd1) begin
            lives_d = 3'd0;
            state_d = S_GAME_OVER;
          end else if (hit) begin
            lives_d = lives_q - 3'd1;
            cnt_d   = 16'd0;
            state_d = S_LIFE_LOST;
          end else if (won_level && level_q == 4'(MAX_LEVEL)) begin
            state_d = S_YOU_WON;
          end else if (won_level) begin
            level_d = level_q + 4'd1;
            state_d = S_LEVEL_INIT;
          end else begin
            state_d = S_RENDER;
          end
        end
      end
      S_RENDER: if (render_done) state_d = S_LOGIC;
      S_LIFE_LOST: begin
        if (cnt_q == PAUSE_CYCLES - 16'd1) state_d = S_LEVEL_INIT;
        else                               cnt_d   = cnt_q + 16'd1;
      end
      S_GAME_OVER, S_YOU_WON: if (screen_done) state_d = S_GREETING;
      default: state_d = S_GREETING;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_GREETING;
      lives_q       <= 3'd0;
      level_q       <= 4'd0;
      cnt_q         <= 16'd0;
      new_game_q    <= 1'b0;
      round_reset_q <= 1'b0;
      e_greeting_q  <= 1'b1;
      e_logic_q     <= 1'b0;
      e_render_q    <= 1'b0;
      e_game_over_q <= 1'b0;
      e_you_won_q   <= 1'b0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      sync3_q       <= 1'b1;
    end else if (enable) begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      new_game_q    <= new_game_d;
      // Decoding the next state keeps the enables aligned with the state register.
      round_reset_q <= (state_d == S_LEVEL_INIT);
      e_greeting_q  <= (state_d == S_GREETING);
      e_logic_q     <= (state_d == S_LOGIC);
      e_render_q    <= (state_d == S_RENDER);
      e_game_over_q <= (state_d == S_GAME_OVER);
      e_you_won_q   <= (state_d == S_YOU_WON);
      sync1_q       <= start_n;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
    end
  end

  logic [1:0] sel;
  logic       draw;

  always_comb begin
    sel  = 2'd0;
    draw = 1'b1;
    case (state_q)
      S_GREETING:  sel = 2'd0;
      S_RENDER:    sel = 2'd1;
      S_GAME_OVER: sel = 2'd2;
      S_YOU_WON:   sel = 2'd3;
      default:     draw = 1'b0;
    endcase
  end

  // The VGA register runs every clock so pixel writes are not gated by enable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      VGA_X     <= 8'd0;
      VGA_Y     <= 7'd0;
      VGA_COLOR <= 12'd0;
      VGA_PLOT  <= 1'b0;
    end else begin
      VGA_X     <= draw ? src_x[sel*8 +: 8]      : 8'd0;
      VGA_Y     <= draw ? src_y[sel*7 +: 7]      : 7'd0;
      VGA_COLOR <= draw ? src_color[sel*12 +: 12] : 12'd0;
      VGA_PLOT  <= draw;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign new_game    = new_game_q;
  assign round_reset = round_reset_q;
  assign e_greeting  = e_greeting_q;
  assign e_logic     = e_logic_q;
  assign e_render    = e_render_q;
  assign e_game_over = e_game_over_q;
  assign e_you_won   = e_you_won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: expectations queued as stimulus is applied, popped when sampled.
module tb_game_flow_ctrl;
  localparam int          NG = 3;
  localparam int          LV = 3;
  localparam int          ML = 2;
  localparam logic [7:0]  WS = 8'd200;
  localparam logic [15:0] PC = 16'd5;

  logic        clock = 1'b0;
  logic        resetn, enable, start_n;
  logic [NG-1:0] ghost_hit;
  logic [7:0]  score;
  logic        logic_done, render_done, screen_done;
  logic [31:0] src_x;
  logic [27:0] src_y;
  logic [47:0] src_color;
  logic        e_greeting, e_logic, e_render, e_game_over, e_you_won;
  logic        new_game, round_reset;
  logic [2:0]  lives;
  logic [3:0]  level;
  logic [2:0]  state;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [11:0] VGA_COLOR;
  logic        VGA_PLOT;

  game_flow_ctrl #(
    .NUM_GHOSTS(NG), .LIVES(LV), .MAX_LEVEL(ML), .WIN_SCORE(WS), .PAUSE_CYCLES(PC)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .start_n(start_n),
    .ghost_hit(ghost_hit), .score(score), .logic_done(logic_done),
    .render_done(render_done), .screen_done(screen_done),
    .src_x(src_x), .src_y(src_y), .src_color(src_color),
    .e_greeting(e_greeting), .e_logic(e_logic), .e_render(e_render),
    .e_game_over(e_game_over), .e_you_won(e_you_won),
    .new_game(new_game), .round_reset(round_reset), .lives(lives), .level(level),
    .state(state), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .VGA_PLOT(VGA_PLOT)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic logic_step(input logic [NG-1:0] hit, input logic [7:0] sc);
    ghost_hit  = hit;
    score      = sc;
    logic_done = 1'b1;
    tick();
    logic_done = 1'b0;
    ghost_hit  = '0;
  endtask

  task automatic press_start();
    start_n = 1'b0;
    expect_v("press_wait_state", 0);
    tick(); tick();
    observe(state);
    expect_v("press_state", 1); expect_v("press_new_game", 1);
    expect_v("press_round_reset", 1); expect_v("press_lives", 3); expect_v("press_level", 1);
    tick();
    observe(state); observe(new_game); observe(round_reset); observe(lives); observe(level);
    start_n = 1'b1;
    expect_v("init_to_logic", 2); expect_v("init_new_game_off", 0); expect_v("e_logic", 1);
    tick();
    observe(state); observe(new_game); observe(e_logic);
  endtask

  task automatic lose_life(input logic [2:0] exp_lives, input logic [3:0] exp_level);
    expect_v("hit_state", 4); expect_v("hit_lives", exp_lives); expect_v("hit_e_logic", 0);
    logic_step(3'b001, 8'd0);
    observe(state); observe(lives); observe(e_logic);
    expect_v("pause_state", 4); expect_v("pause_plot", 0);
    for (int i = 1; i < int'(PC); i++) tick();
    observe(state); observe(VGA_PLOT);
    expect_v("pause_exit", 1); expect_v("pause_round_reset", 1);
    expect_v("pause_new_game", 0); expect_v("pause_level", exp_level);
    tick();
    observe(state); observe(round_reset); observe(new_game); observe(level);
    expect_v("pause_to_logic", 2);
    tick();
    observe(state);
  endtask

  initial begin
    int ng_cnt;
    resetn = 1'b0; enable = 1'b1; start_n = 1'b1; ghost_hit = '0; score = 8'd0;
    logic_done = 1'b0; render_done = 1'b0; screen_done = 1'b0;
    src_x     = 32'hD4C3B2A1;
    src_y     = {7'h44, 7'h33, 7'h22, 7'h11};
    src_color = {12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA};

    expect_v("rst_state", 0); expect_v("rst_lives", 0); expect_v("rst_level", 0);
    expect_v("rst_e_greeting", 1); expect_v("rst_e_logic", 0); expect_v("rst_new_game", 0);
    expect_v("rst_round_reset", 0); expect_v("rst_plot", 0); expect_v("rst_vga_x", 0);
    tick(); tick();
    observe(state); observe(lives); observe(level); observe(e_greeting); observe(e_logic);
    observe(new_game); observe(round_reset); observe(VGA_PLOT); observe(VGA_X);

    resetn = 1'b1;
    expect_v("greet_vga_x", 32'hA1); expect_v("greet_vga_y", 32'h11); expect_v("greet_plot", 1);
    tick();
    observe(VGA_X); observe(VGA_Y); observe(VGA_PLOT);

    press_start();

    expect_v("render_state", 3); expect_v("render_en", 1); expect_v("render_vga_lag", 0);
    logic_step(3'b000, 8'd10);
    observe(state); observe(e_render); observe(VGA_PLOT);
    expect_v("render_vga_x", 32'hB2); expect_v("render_vga_y", 32'h22);
    expect_v("render_color", 32'hBBB); expect_v("render_plot", 1); expect_v("render_hold", 3);
    tick();
    observe(VGA_X); observe(VGA_Y); observe(VGA_COLOR); observe(VGA_PLOT); observe(state);
    expect_v("render_done", 2);
    render_done = 1'b1; tick(); render_done = 1'b0;
    observe(state);

    expect_v("stray_done", 2);
    render_done = 1'b1; screen_done = 1'b1; tick();
    render_done = 1'b0; screen_done = 1'b0;
    observe(state);

    expect_v("enable_low_hold", 2); expect_v("enable_low_lives", 3);
    enable = 1'b0; logic_done = 1'b1; score = 8'd10;
    tick(); tick();
    logic_done = 1'b0; enable = 1'b1;
    observe(state); observe(lives);

    expect_v("score_199", 3);
    logic_step(3'b000, 8'd199);
    observe(state);
    render_done = 1'b1; tick(); render_done = 1'b0;

    lose_life(3'd2, 4'd1);
    lose_life(3'd1, 4'd1);
    expect_v("over_state", 5); expect_v("over_lives", 0); expect_v("over_en", 1);
    logic_step(3'b100, 8'd0);
    observe(state); observe(lives); observe(e_game_over);
    expect_v("over_vga_x", 32'hC3); expect_v("over_color", 32'hCCC);
    tick();
    observe(VGA_X); observe(VGA_COLOR);
    expect_v("over_exit", 0); expect_v("over_e_greeting", 1);
    screen_done = 1'b1; tick(); screen_done = 1'b0;
    observe(state); observe(e_greeting);

    press_start();
    expect_v("lvl_up_state", 1); expect_v("lvl_up_level", 2);
    expect_v("lvl_up_new_game", 0); expect_v("lvl_up_round_reset", 1);
    logic_step(3'b000, 8'd200);
    observe(state); observe(level); observe(new_game); observe(round_reset);
    expect_v("lvl2_logic", 2);
    tick();
    observe(state);
    expect_v("won_state", 6); expect_v("won_en", 1); expect_v("won_level", 2);
    logic_step(3'b000, 8'd200);
    observe(state); observe(e_you_won); observe(level);
    expect_v("won_vga_x", 32'hD4); expect_v("won_vga_y", 32'h44);
    expect_v("won_color", 32'hDDD); expect_v("won_plot", 1);
    tick();
    observe(VGA_X); observe(VGA_Y); observe(VGA_COLOR); observe(VGA_PLOT);
    expect_v("won_exit", 0);
    screen_done = 1'b1; tick(); screen_done = 1'b0;
    observe(state);

    press_start();
    lose_life(3'd2, 4'd1);
    lose_life(3'd1, 4'd1);
    expect_v("hit_beats_win", 5); expect_v("hit_beats_win_lives", 0);
    logic_step(3'b111, 8'd200);
    observe(state); observe(lives);
    screen_done = 1'b1; tick(); screen_done = 1'b0;

    press_start();
    logic_step(3'b000, 8'd10);
    expect_v("pre_reset_plot", 1);
    tick();
    observe(VGA_PLOT);
    expect_v("async_rst_state", 0); expect_v("async_rst_plot", 0);
    expect_v("async_rst_lives", 0); expect_v("async_rst_level", 0); expect_v("async_rst_e_greeting", 1);
    #2 resetn = 1'b0;
    #1;
    observe(state); observe(VGA_PLOT); observe(lives); observe(level); observe(e_greeting);
    tick();
    resetn = 1'b1;

    start_n = 1'b0;
    ng_cnt = 0;
    expect_v("hold_new_game_count", 1); expect_v("hold_state", 2); expect_v("hold_lives", 3);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (new_game) ng_cnt++;
    end
    observe(ng_cnt); observe(state); observe(lives);
    start_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game-flow controller for the maze game: sequences greeting, round setup, logic/render alternation, life loss, game over and win, and drives the shared VGA write port from one of four screen sources. Replaces the fixed three-ghost, no-win, single-life sequencer with configurable ghost count, lives, levels and a life-lost pause. It sits between the PS/2 and button front end and the greeting, logic, renderer, collision and end-screen blocks.

## Interface
- NUM_GHOSTS, 3: ghost count, 1..8; sets the collision vector width.
- LIVES, 3: lives per game, 1..7.
- MAX_LEVEL, 4: levels to clear for a win, 1..15.
- WIN_SCORE, 8'd200: score at or above which the current level is cleared.
- PAUSE_CYCLES, 16'd50000: enabled cycles spent in LIFE_LOST.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  advance strobe; state, counters and synchroniser update only when it is 1.
- start_n  in  1  raw active-low start button, asynchronous.
- ghost_hit  in  NUM_GHOSTS  per-ghost collision flags, valid while logic_done is 1.
- score  in  8  current score from the logic block.
- logic_done, render_done, screen_done  in  1 each  completion pulses from the logic block, the renderer and the active end screen.
- src_x  in  32  four packed 8-bit X values, index 0 greeting, 1 render, 2 game over, 3 won.
- src_y  in  28  four packed 7-bit Y values, same indexing.
- src_color  in  48  four packed 12-bit colours, same indexing.
- e_greeting, e_logic, e_render, e_game_over, e_you_won  out  1 each  one-hot sub-block enables.
- new_game  out  1  one-cycle pulse that clears the score.
- round_reset  out  1  one-cycle pulse that resets actor positions.
- lives  out  3  remaining lives.
- level  out  4  current level, 1-based.
- state  out  3  current state code, for debug.
- VGA_X  out  8  registered pixel X.
- VGA_Y  out  7  registered pixel Y.
- VGA_COLOR  out  12  registered pixel colour.
- VGA_PLOT  out  1  registered write enable.

## Operation
- State codes: GREETING=0, LEVEL_INIT=1, LOGIC=2, RENDER=3, LIFE_LOST=4, GAME_OVER=5, YOU_WON=6. Codes 7 and any other unused code go to GREETING.
- Start detection:
  - start_n passes through a 2-flop synchroniser clocked on enable cycles.
  - A press is a synchronised 1->0 edge; one press gives exactly one event.
- GREETING: e_greeting=1. On a press, load lives=LIVES and level=1, pulse new_game, then go to LEVEL_INIT.
- LEVEL_INIT: stays one enabled cycle, pulses round_reset, then goes to LOGIC.
- LOGIC: e_logic=1. Waits for logic_done, then takes the first matching row:
  - any ghost_hit bit set and lives==1: lives←0, go to GAME_OVER.
  - any ghost_hit bit set and lives>1: lives←lives-1, clear the pause counter, go to LIFE_LOST.
  - score≥WIN_SCORE and level==MAX_LEVEL: go to YOU_WON.
  - score≥WIN_SCORE and level<MAX_LEVEL: level←level+1, go to LEVEL_INIT. The score is not cleared.
  - otherwise: go to RENDER.
  - Collision takes precedence over a win in the same cycle.
- RENDER: e_render=1. On render_done, go to LOGIC.
- LIFE_LOST:
  - No sub-block enable is asserted.
  - The counter counts enabled cycles; at PAUSE_CYCLES-1 go to LEVEL_INIT.
  - Score and level are kept.
- GAME_OVER (e_game_over=1) and YOU_WON (e_you_won=1): on screen_done, go to GREETING.
- Done pulses that arrive in a state not waiting for them are ignored.
- VGA mux source by state:
  - GREETING: source 0.
  - RENDER: source 1.
  - GAME_OVER: source 2.
  - YOU_WON: source 3.
  - All other states: X=0, Y=0, COLOR=0, PLOT=0.
  - VGA_PLOT=1 in the four drawing states.

## Timing
- Reset values:
  - state=GREETING, lives=0, level=0.
  - synchroniser flops=1.
  - All pulses, enables and VGA outputs 0, except e_greeting, which is 1 because it decodes GREETING.
- Enables are Moore decodes of state, so they change in the same cycle as the state.
- Transitions are registered: a done pulse or press seen in cycle n gives the new state in cycle n+1, provided enable=1 in cycle n.
- Press to leaving GREETING takes 3 enabled cycles: 2 synchroniser stages plus the edge.
- new_game is high in the first LEVEL_INIT cycle after GREETING.
- round_reset is high in every LEVEL_INIT cycle.
- VGA outputs lag the state and source inputs by exactly 1 clock. They do not depend on enable.
- LIFE_LOST lasts exactly PAUSE_CYCLES enabled cycles.
- When enable=0 every register holds its value, except the VGA output register.
- resetn is asynchronous: asserting it mid-game returns the block to GREETING immediately with lives and level cleared.

## Test plan
- Reset, then press start with enable=1: 3 cycles later state=1 with new_game=1 and round_reset=1, lives=3, level=1; one cycle later state=2.
- Logic and render loop: logic_done with no hit and score=10 gives state=3; render_done returns to state=2. Check VGA_X equals src_x[15:8] one cycle after entering RENDER.
- Collision with lives=3: go to LIFE_LOST with lives=2, stay exactly PAUSE_CYCLES cycles, then LEVEL_INIT then LOGIC. Repeat until lives=1, then a hit gives GAME_OVER with lives=0; screen_done returns to GREETING.
- Win progression with MAX_LEVEL=2: score=200 at logic_done gives level=2 and LEVEL_INIT; score=200 again gives YOU_WON; e_you_won=1 and VGA sourced from index 3.
- Simultaneous collision and score≥WIN_SCORE with lives=1: go to GAME_OVER, not YOU_WON.
- Holding start_n low for 100 cycles gives one press; pulling resetn low mid-RENDER gives state=0 and VGA_PLOT=0 immediately.
